// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
    localparam int          IMEM_AW_DEFAULT  = 11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        oob;
    } fetch_entry_t;

    function automatic logic [29:0] pc_word(input logic [31:0] pc);
        return pc[31:2];
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bus between the fetch stage, the instruction ROM, the redirect source and decode.
interface if_fetch_stage_if #(
    parameter int IMEM_AW = 11
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [31:0]        out_pc;
    logic [31:0]        out_pc4;
    logic               out_oob;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output out_pc4,
        output out_oob
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  out_pc4,
        input  out_oob
    );
endinterface

// File: rtl/fetch_queue2.sv
// Two-entry circular queue of fetch entries; head reads as zero when empty.
module fetch_queue2
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_din,
    output logic [1:0]   o_count,
    output logic         o_valid,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; a full-queue push overwrites the slot being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        o_count = r_count;
        o_valid = 1'b0;
        o_head  = '0;
        if (r_count != 2'd0) begin
            o_valid = 1'b1;
            o_head  = r_mem[r_rd_ptr];
        end else begin
            o_valid = 1'b0;
            o_head  = '0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the ROM and queues fetched words for decode.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    if_fetch_stage_if.master    bus
);

    // PC is kept word-aligned, so only bits [31:2] are stored.
    logic [29:0]  r_pc_word;
    logic [29:0]  w_off_word;
    logic         w_oob;
    logic         w_pop;
    logic         w_push;
    logic [1:0]   w_count;
    logic         w_valid;
    fetch_entry_t w_din;
    fetch_entry_t w_head;

    assign w_off_word = r_pc_word - pc_word(PC_RESET);
    assign w_oob      = |w_off_word[29:IMEM_AW];

    // Push/pop decisions and the entry written at the tail.
    always_comb begin
        w_pop  = w_valid && bus.out_ready;
        w_push = 1'b0;
        if (bus.redirect_valid) begin
            w_push = 1'b0;
        end else begin
            w_push = (w_count < 2'd2) || w_pop;
        end
        w_din.pc   = {r_pc_word, 2'b00};
        w_din.inst = bus.imem_data;
        w_din.oob  = w_oob;
    end

    // Program counter: redirect has priority, otherwise advance on each push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_word <= pc_word(PC_RESET);
        end else if (bus.redirect_valid) begin
            r_pc_word <= pc_word(bus.redirect_pc);
        end else if (w_push) begin
            r_pc_word <= r_pc_word + 30'd1;
        end
    end

    fetch_queue2 u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_din   (w_din),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_head  (w_head)
    );

    assign bus.imem_addr = w_off_word[IMEM_AW-1:0];
    assign bus.out_valid = w_valid;
    assign bus.out_inst  = w_head.inst;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_oob   = w_head.oob;
    assign bus.out_pc4   = w_valid ? (w_head.pc + 32'd4) : 32'd0;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the 2048x32 asynchronous-read instruction ROM.
- Owns the program counter and drives the ROM word address.
- Captures the returned instruction together with its PC into a 2-entry queue.
- Presents entries to decode through a valid/ready handshake; a branch/jump redirect flushes the queue and reloads the PC.

Parameters:
- PC_RESET, 32'h0040_0000, PC value after reset; also the base subtracted to form the ROM address.
- IMEM_AW, 11, ROM word-address width; ROM depth is 2^IMEM_AW words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_addr  out  IMEM_AW  ROM word address, combinational from pc: (pc - PC_RESET)[IMEM_AW+1:2].
- imem_data  in  32  ROM read data, valid in the same cycle as imem_addr.
- redirect_valid  in  1  one-cycle request to load a new PC (taken branch/jump/exception).
- redirect_pc  in  32  target PC; bits [1:0] ignored.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  instruction at queue head.
- out_pc  out  32  PC of the head instruction.
- out_pc4  out  32  out_pc + 4.
- out_oob  out  1  head PC was outside the ROM window when fetched.

Behaviour:
- Reset (async, rst_n=0):
  - pc=PC_RESET, queue count=0.
  - out_valid=0; out_inst, out_pc, out_pc4 and out_oob read 0.
  - Everything else is state-free.
- ROM address: offset = pc - PC_RESET (32-bit, wraps); imem_addr = offset[IMEM_AW+1:2]. The ROM index therefore wraps modulo 2^IMEM_AW.
- Out-of-bounds flag: oob = (offset >= 4*2^IMEM_AW), which includes PCs below PC_RESET because the offset wraps. oob is stored with the entry. The instruction is still captured; decode decides what to do with it.
- pop = out_valid && out_ready.
- push = !redirect_valid && (count<2 || pop).
  - A full queue accepts a push in the same cycle as a pop, so throughput is 1 instruction/cycle.
- On push:
  - Write {pc, imem_data, oob} at the tail.
  - pc <= pc + 4 (32-bit wrap).
- Redirect (redirect_valid=1) has priority over push and pop:
  - count <= 0 and both entries are discarded.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - A head accepted by decode in the same cycle (pop) is considered consumed; ordering against the redirect is decode's responsibility.
- Latency:
  - Without a redirect, the instruction at pc appears on out_* one cycle after it is addressed.
  - After a redirect at edge N, the target is addressed in cycle N+1 and valid at out_* after edge N+1.
  - The redirect costs exactly one bubble cycle at the queue output when decode is always ready.
- Queue:
  - Circular, 2 entries, with rd_ptr, wr_ptr (1 bit each) and count (0..2).
  - out_* are driven from entry[rd_ptr], registered storage with no combinational path from imem_data.
  - When count=0, out_* read 0.
- Backpressure: with out_ready=0 and count=2, pc holds, imem_addr holds and nothing is pushed.
- A reset asserted mid-operation clears everything asynchronously. The first push happens at the first rising edge after rst_n deasserts, and out_valid=1 after that edge.

Decomposition:
- Package if_pkg:
  - PC_RESET_DEFAULT=32'h0040_0000.
  - IMEM_AW_DEFAULT=11.
  - typedef fetch_entry_t {pc[31:0], inst[31:0], oob}.
- Sub-module fetch_queue2:
  - Generic 2-deep valid/ready queue of fetch_entry_t with push, pop, flush, count, head.
  - The top-level holds the PC, address arithmetic and control.

Test Plan:
- Reset release, out_ready=1, ROM[i]=i: out_pc = 0x0040_0000, 0x0040_0004, ... on consecutive cycles; out_inst = 0,1,2,...; no bubbles.
- out_ready=0 for 5 cycles after reset: count saturates at 2 and imem_addr freezes at 2. On release, out_pc = 0x00400000, 0x00400004, 0x00400008 back-to-back with no loss or duplication.
- Redirect to 0x0040_0103 with a full queue: the next valid output is pc=0x0040_0100, inst=ROM[0x40], after exactly one bubble; both stale entries never appear.
- Redirect to 0x0040_2000: out_oob=1 and imem_addr=0 (wrap). Redirect to 0x003F_FFFC: out_oob=1 and imem_addr=0x7FF.
- Simultaneous pop and push at count=2 with out_ready toggling every cycle: the output sequence stays strictly sequential and out_pc4 = out_pc+4 on every valid cycle.
- rst_n pulsed low mid-stream (between edges): out_valid drops immediately; after release the fetch restarts at 0x0040_0000.
